crc8_arbiter: RTL and testbench
===============================

CRC8_ARBITER -- requirements
Module: crc8_arbiter

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial with x^8 implied, processed MSB-first.
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register value at frame start.
REQ-003 SHALL have parameter XOROUT, default 8'h00, XOR mask applied to the CRC register to form res_crc.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  2  per-port byte valid.
REQ-007 req_data0, req_data1  in  8 each  per-port data byte.
REQ-008 req_last  in  2  per-port flag marking the last byte of a frame.
REQ-009 req_ready  out  2  per-port byte accept; at most one bit high.
REQ-010 res_valid  out  1  result available.
REQ-011 res_crc  out  8  frame CRC, equal to CRC register ^ XOROUT.
REQ-012 res_id  out  1  port that owned the frame.
REQ-013 res_len  out  8  bytes in the frame, saturating at 255.
REQ-014 res_ready  in  1  result consumer accept.
REQ-015 busy  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH, SHIFT, DONE.
REQ-017 IDLE: when any req_valid is high, SHALL grant one port by round-robin pointer, load CRC = INIT and len = 0, and go to FETCH next cycle.
- If both ports are valid, the port equal to the pointer wins.
- Pointer resets to 0.
REQ-018 FETCH: req_ready[grant] SHALL be high combinationally; all other req_ready low.
REQ-019 FETCH: on req_valid[grant] high, SHALL capture byte and last flag, increment len (saturating), and go to SHIFT with bit counter = 0.
REQ-020 FETCH with req_valid[grant] low SHALL wait indefinitely, holding the grant; the other port is never serviced mid-frame.
REQ-021 SHIFT: SHALL process one bit per cycle, MSB first, for exactly 8 cycles:
- fb = crc[7] ^ bit
- crc = (crc << 1) ^ (fb ? POLY : 0)
REQ-022 After the 8th SHIFT cycle, SHALL go to DONE if the captured last flag is set, else to FETCH.
REQ-023 Throughput SHALL be 9 cycles per byte; with req_valid held high, res_valid rises 1 + 9n cycles after IDLE first samples the request, for an n-byte frame.
REQ-024 DONE: res_valid SHALL be high, with res_crc, res_id and res_len stable until res_ready is sampled high.
- On that cycle: set pointer = ~grant and go to IDLE.
- Result is not re-presented.
REQ-025 A byte presented on the non-granted port SHALL not be accepted and SHALL wait for its own grant.
REQ-026 A zero-length frame is impossible; every frame contains at least one byte, namely the one with req_last.

Reset
REQ-027 rst high SHALL force, on the next edge:
- state IDLE, pointer 0, CRC = INIT, len 0, bit counter 0
- res_valid 0, req_ready 0, busy 0, res_crc 0, res_id 0, res_len 0
REQ-028 rst asserted mid-frame (any state) SHALL abort the frame with no result produced; a byte captured in FETCH is discarded.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-030 Shared package crc8_pkg SHALL hold the FSM state enum and the default POLY, INIT and XOROUT constants.
REQ-031 The bit-serial CRC register SHALL be a sub-module crc8_core:
- inputs: clear-to-INIT, shift enable, data bit
- output: 8-bit CRC
- no knowledge of ports or framing
REQ-032 Arbitration, framing, length count and result handshake SHALL live in crc8_arbiter.

Verification
REQ-033 Port0 sends 0x41 with last=1; res_ready held high -> res_valid 10 cycles after request, res_crc=0xC0, res_id=0, res_len=1.
REQ-034 Port1 sends ASCII "123456789", valid continuous -> res_crc=0xF4, res_id=1, res_len=9, at cycle 82.
REQ-035 Both ports request a one-byte frame of 0x41 simultaneously after reset -> port0 result first, then port1 result; both CRC 0xC0; req_ready never high on both ports.
REQ-036 Port0 two-byte frame with req_valid dropped for 5 cycles between bytes, while port1 is valid throughout -> port0 frame completes first, with no port1 byte accepted during the gap.
REQ-037 res_ready held low for 20 cycles in DONE -> res_valid, res_crc, res_id and res_len stable throughout; exactly one result is transferred.
REQ-038 rst pulsed during the 4th SHIFT cycle -> no res_valid; busy=0 next cycle; a subsequent 0x41 frame on port0 yields 0xC0.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 arbiter: FSM state encoding and default CRC parameters.
package crc8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam logic [7:0] CRC8_XOROUT = 8'h00;

endpackage

// File: rtl/crc8_core.sv
// Bit-serial CRC-8 register, MSB-first; knows nothing about ports or framing.
module crc8_core
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ din;

  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= INIT;
    end else if (shift_en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
  end

endmodule

// File: rtl/crc8_arbiter.sv
// Two-port round-robin frame arbiter feeding a shared bit-serial CRC-8 engine,
// returning CRC, owning port and saturating length per frame.
module crc8_arbiter
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY   = CRC8_POLY,
  parameter logic [7:0] INIT   = CRC8_INIT,
  parameter logic [7:0] XOROUT = CRC8_XOROUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic       res_valid,
  output logic [7:0] res_crc,
  output logic       res_id,
  output logic [7:0] res_len,
  input  logic       res_ready,
  output logic       busy
);

  state_t     state;
  logic       ptr;
  logic       grant;
  logic       last_q;
  logic [7:0] byte_q;
  logic [7:0] len;
  logic [2:0] bitcnt;
  logic [7:0] crc;
  logic       core_clear;
  logic       core_shift;
  logic       accept;
  logic [7:0] grant_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign grant_data = grant ? req_data1 : req_data0;
  assign accept     = (state == FETCH) && req_valid[grant];
  assign core_clear = rst || ((state == IDLE) && (|req_valid));
  assign core_shift = (state == SHIFT);
  assign busy       = (state != IDLE);
  // The CRC register is frozen in DONE, so the result can be read straight from it.
  assign res_crc    = res_valid ? (crc ^ XOROUT) : 8'h00;

  always_comb begin
    req_ready = 2'b00;
    if (state == FETCH) req_ready[grant] = 1'b1;
  end

  crc8_core #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_core (
    .clk      (clk),
    .clear    (core_clear),
    .shift_en (core_shift),
    .din      (byte_q[7]),
    .crc      (crc)
  );

  // Captured byte is consumed MSB-first by shifting left.
  always_ff @(posedge clk) begin
    if (accept) begin
      byte_q <= grant_data;
      last_q <= req_last[grant];
    end else if (state == SHIFT) begin
      byte_q <= {byte_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      grant     <= 1'b0;
      len       <= 8'h00;
      bitcnt    <= 3'd0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_len   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant  <= req_valid[ptr] ? ptr : ~ptr;
            len    <= 8'h00;
            bitcnt <= 3'd0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (req_valid[grant]) begin
            len    <= sat_inc(len);
            bitcnt <= 3'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (last_q) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_id    <= grant;
              res_len   <= len;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= ~grant;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_arbiter.sv
// Scoreboard bench for crc8_arbiter: directed scenarios plus randomized frames against a byte-wise CRC model.
module tb_crc8_arbiter;

  localparam logic [7:0] POLY   = 8'h07;
  localparam logic [7:0] INIT   = 8'h00;
  localparam logic [7:0] XOROUT = 8'h00;

  typedef struct packed {
    logic [7:0] crc;
    logic       id;
    logic [7:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       res_ready = 1'b1;
  logic [1:0] req_ready;
  logic       res_valid;
  logic [7:0] res_crc;
  logic       res_id;
  logic [7:0] res_len;
  logic       busy;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   xfers = 0;
  int   acc1 = 0;
  int   rr_mode = 0;
  logic ptr_m = 1'b0;

  logic       hold = 1'b0;
  logic [7:0] snap_crc, snap_len;
  logic       snap_id;

  crc8_arbiter #(
    .POLY   (POLY),
    .INIT   (INIT),
    .XOROUT (XOROUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid ({v1, v0}),
    .req_data0 (d0),
    .req_data1 (d1),
    .req_last  ({l1, l0}),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_crc   (res_crc),
    .res_id    (res_id),
    .res_len   (res_len),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: standard byte-wise CRC-8 definition.
  function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    c = INIT;
    foreach (b[i]) begin
      c = c ^ b[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c ^ XOROUT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] b[$], input logic id);
    exp_t e;
    e.crc = ref_crc(b);
    e.id  = id;
    e.len = (b.size() > 255) ? 8'd255 : 8'(b.size());
    sb.push_back(e);
    ptr_m = ~id;
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin v0 = v; d0 = d; l0 = l; end
    else begin v1 = v; d1 = d; l1 = l; end
  endtask

  // Called and returns at posedge+1.
  task automatic send_frame(input int p, input logic [7:0] b[$], input int gmin, input int gmax);
    int k;
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0) begin
        drive(p, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
      end
      drive(p, 1'b1, b[i], (i == b.size() - 1));
      k = 0;
      do begin @(negedge clk); k++; end while (!req_ready[p] && k < 4000);
      if (k >= 4000) begin
        chk($sformatf("accept_timeout_p%0d", p), 32'd0, 32'd1);
        drive(p, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk); #1;
    end
    drive(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic measure_latency(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_valid && n < 400);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 6000) begin @(posedge clk); #1; k++; end
    if (k >= 6000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: output handshake, hold stability and grant exclusivity.
  always @(negedge clk) begin
    exp_t e;
    chk("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
    if (v1 && req_ready[1]) acc1++;
    if (hold && res_valid) begin
      chk("hold_crc", res_crc, snap_crc);
      chk("hold_id", res_id, snap_id);
      chk("hold_len", res_len, snap_len);
    end
    if (res_valid && !res_ready && !rst) begin
      hold = 1'b1; snap_crc = res_crc; snap_id = res_id; snap_len = res_len;
    end else begin
      hold = 1'b0;
    end
    if (res_valid && res_ready && !rst) begin
      xfers++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_crc", res_crc, e.crc);
        chk("res_id", res_id, e.id);
        chk("res_len", res_len, e.len);
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q0[$], q1[$];
    logic       first;
    int         lat, base, abase, k, mode;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_crc", res_crc, 8'h00);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_len", res_len, 8'h00);
    @(posedge clk); #1;

    // Single byte on port0, latency 10.
    q0 = {8'h41};
    push_exp(q0, 1'b0);
    fork
      send_frame(0, q0, 0, 0);
      measure_latency(lat);
    join
    chk("lat_1byte", lat, 10);
    chk("crc_A_model", ref_crc(q0), 8'hC0);
    wait_drain();

    // "123456789" on port1, latency 82.
    q1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_exp(q1, 1'b1);
    fork
      send_frame(1, q1, 0, 0);
      measure_latency(lat);
    join
    chk("lat_9byte", lat, 82);
    wait_drain();

    // Simultaneous one-byte frames.
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0; ptr_m = 1'b0;
    q0 = {8'h41};
    push_exp(q0, 1'b0);
    push_exp(q0, 1'b1);
    fork
      send_frame(0, q0, 0, 0);
      send_frame(1, q0, 0, 0);
    join
    wait_drain();

    // Port0 gap of 5 cycles while port1 waits.
    q0 = {8'hA5, 8'h3C};
    q1 = {8'h11, 8'h22};
    first = ptr_m;
    push_exp(first ? q1 : q0, first);
    push_exp(first ? q0 : q1, ~first);
    base = xfers; abase = acc1;
    fork
      send_frame(0, q0, 5, 5);
      send_frame(1, q1, 0, 0);
      begin
        k = 0;
        while (xfers == base && k < 2000) begin @(posedge clk); #1; k++; end
        chk("no_p1_accept_in_p0_frame", acc1 - abase, 0);
      end
    join
    wait_drain();

    // Consumer stalls 20 cycles in DONE.
    rr_mode = 2;
    @(posedge clk); #1;
    rand_bytes(q0, 3);
    push_exp(q0, 1'b0);
    base = xfers;
    send_frame(0, q0, 0, 1);
    k = 0;
    while (!res_valid && k < 200) begin @(posedge clk); #1; k++; end
    repeat (20) begin @(posedge clk); #1; end
    chk("stall_valid_held", res_valid, 1'b1);
    rr_mode = 0;
    wait_drain();
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_one_xfer", xfers - base, 1);

    // Reset during the 4th SHIFT cycle aborts the frame.
    drive(0, 1'b1, 8'h41, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ptr_m = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_no_result", res_valid, 1'b0);
    q0 = {8'h41};
    push_exp(q0, 1'b0);
    send_frame(0, q0, 0, 0);
    wait_drain();

    // Length saturation.
    rand_bytes(q1, 260);
    push_exp(q1, 1'b1);
    send_frame(1, q1, 0, 0);
    wait_drain();

    // Randomized rounds.
    rr_mode = 1;
    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(2, 0);
      rand_bytes(q0, $urandom_range(6, 1));
      rand_bytes(q1, $urandom_range(6, 1));
      if (mode == 0) begin
        first = ptr_m;
        push_exp(first ? q1 : q0, first);
        push_exp(first ? q0 : q1, ~first);
        fork
          send_frame(0, q0, 0, 2);
          send_frame(1, q1, 0, 2);
        join
      end else if (mode == 1) begin
        push_exp(q0, 1'b0);
        send_frame(0, q0, 0, 2);
      end else begin
        push_exp(q1, 1'b1);
        send_frame(1, q1, 0, 2);
      end
      wait_drain();
    end
    rr_mode = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
